// File: rtl/riscv_pkg.sv
// Shared core parameters and address helpers used by the store buffer.
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int SB_DEPTH = 4;

   // Word index of a byte address; the low two bits select a byte within the word.
   function automatic logic [XLEN-3:0] word_idx(input logic [XLEN-1:0] addr);
      return addr[XLEN-1:2];
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Signal bundle for the store buffer: retire-side enqueue, memory write port, load forwarding.
interface store_buffer_if
   import riscv_pkg::*;
#(
   parameter int AW = XLEN
);

   // Enqueue: a store transfers on the rising edge where enq_valid && enq_ready;
   // enq_ready depends only on registered occupancy, never on enq_valid or drain_stall.
   logic          enq_valid;
   logic [AW-1:0] enq_addr;
   logic [AW-1:0] enq_data;
   logic          enq_ready;
   logic          drain_stall;
   logic          mem_WE;
   logic [AW-1:0] mem_A;
   logic [AW-1:0] mem_WD;
   logic [AW-1:0] ld_addr;
   logic          ld_hit;
   logic [AW-1:0] ld_data;
   logic          empty;

   modport master (
      output enq_valid, enq_addr, enq_data, drain_stall, ld_addr,
      input  enq_ready, mem_WE, mem_A, mem_WD, ld_hit, ld_data, empty
   );

   modport slave (
      input  enq_valid, enq_addr, enq_data, drain_stall, ld_addr,
      output enq_ready, mem_WE, mem_A, mem_WD, ld_hit, ld_data, empty
   );

endinterface

// File: rtl/sb_fwd_match.sv
// Youngest-match select for store-to-load forwarding over age-ordered entries (index 0 = oldest).
module sb_fwd_match
   import riscv_pkg::*;
#(
   parameter int N  = SB_DEPTH,
   parameter int AW = XLEN
) (
   input  logic [N-1:0]  valid,
   input  logic [AW-1:0] entry_addr [N],
   input  logic [AW-1:0] entry_data [N],
   input  logic [AW-1:0] ld_addr,
   output logic          hit,
   output logic [AW-1:0] data
);

   localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

   // Later (younger) matches overwrite earlier ones, giving youngest-wins priority.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < N; i++) begin
         if (valid[i] && (((entry_addr[i] ^ ld_addr) & WORD_MASK) == '0)) begin
            hit  = 1'b1;
            data = entry_data[i];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between retire and data memory, with youngest-entry load forwarding.
module store_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = XLEN
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enq_valid,
   input  logic [AW-1:0] enq_addr,
   input  logic [AW-1:0] enq_data,
   output logic          enq_ready,
   input  logic          drain_stall,
   output logic          mem_WE,
   output logic [AW-1:0] mem_A,
   output logic [AW-1:0] mem_WD,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic [AW-1:0] ld_data,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] data_q [DEPTH];

   logic          do_enq;
   logic          do_pop;
   logic [DEPTH-1:0] ord_valid;
   logic [AW-1:0] ord_addr [DEPTH];
   logic [AW-1:0] ord_data [DEPTH];

   assign empty     = (count == '0);
   assign enq_ready = (count != CW'(DEPTH));
   assign do_enq    = enq_valid && enq_ready && !reset;
   assign mem_WE    = !empty && !drain_stall;
   assign do_pop    = mem_WE;
   // Gate with empty so stale, unreset entry contents never reach the memory port.
   assign mem_A     = empty ? '0 : addr_q[head];
   assign mem_WD    = empty ? '0 : data_q[head];

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_enq) tail <= tail + PW'(1);
         if (do_pop) head <= head + PW'(1);
         case ({do_enq, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) begin
         addr_q[tail] <= enq_addr & WORD_MASK;
         data_q[tail] <= enq_data;
      end
   end

   // Rotate storage so slot 0 is the head (oldest); the draining entry stays visible.
   always_comb begin
      ord_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ord_addr[i]  = addr_q[head + PW'(i)];
         ord_data[i]  = data_q[head + PW'(i)];
         ord_valid[i] = (CW'(i) < count);
      end
   end

   sb_fwd_match #(
      .N  (DEPTH),
      .AW (AW)
   ) u_fwd (
      .valid      (ord_valid),
      .entry_addr (ord_addr),
      .entry_data (ord_data),
      .ld_addr    (ld_addr),
      .hit        (ld_hit),
      .data       (ld_data)
   );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, backpressure, forwarding priority, wrap and reset.
module tb_store_buffer;
   import riscv_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   logic [63:0] exp_q [$];

   store_buffer_if #(.AW(32)) sb ();

   store_buffer #(.DEPTH(4), .AW(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .enq_valid   (sb.enq_valid),
      .enq_addr    (sb.enq_addr),
      .enq_data    (sb.enq_data),
      .enq_ready   (sb.enq_ready),
      .drain_stall (sb.drain_stall),
      .mem_WE      (sb.mem_WE),
      .mem_A       (sb.mem_A),
      .mem_WD      (sb.mem_WD),
      .ld_addr     (sb.ld_addr),
      .ld_hit      (sb.ld_hit),
      .ld_data     (sb.ld_data),
      .empty       (sb.empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock slot: drive inputs, check outputs against the queue model, advance.
   task automatic cycle(input logic ev, input logic [31:0] a, input logic [31:0] d,
                        input logic stall);
      logic exp_rdy;
      logic exp_we;
      sb.enq_valid   = ev;
      sb.enq_addr    = a;
      sb.enq_data    = d;
      sb.drain_stall = stall;
      #1;
      exp_rdy = (exp_q.size() != 4);
      exp_we  = (exp_q.size() != 0) && !stall;
      check("enq_ready", 32'(sb.enq_ready), 32'(exp_rdy));
      check("mem_WE", 32'(sb.mem_WE), 32'(exp_we));
      check("empty", 32'(sb.empty), 32'(exp_q.size() == 0));
      if (exp_we) begin
         check("mem_A", sb.mem_A, exp_q[0][63:32]);
         check("mem_WD", sb.mem_WD, exp_q[0][31:0]);
      end
      @(posedge clk);
      #1;
      if (exp_we) void'(exp_q.pop_front());
      if (ev && exp_rdy) exp_q.push_back({a, d});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      sb.enq_valid   = 1'b0;
      sb.enq_addr    = '0;
      sb.enq_data    = '0;
      sb.drain_stall = 1'b0;
      sb.ld_addr     = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;

      // Reset state
      check("rst_enq_ready", 32'(sb.enq_ready), 32'd1);
      check("rst_mem_WE", 32'(sb.mem_WE), 32'd0);
      check("rst_mem_A", sb.mem_A, 32'h0);
      check("rst_mem_WD", sb.mem_WD, 32'h0);
      check("rst_ld_hit", 32'(sb.ld_hit), 32'd0);
      check("rst_ld_data", sb.ld_data, 32'h0);
      check("rst_empty", 32'(sb.empty), 32'd1);

      // Single store; the store being enqueued must not forward in its own cycle
      sb.ld_addr   = 32'h10;
      sb.enq_valid = 1'b1;
      sb.enq_addr  = 32'h10;
      sb.enq_data  = 32'hDEADBEEF;
      #1;
      check("no_bypass_hit", 32'(sb.ld_hit), 32'd0);
      cycle(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      sb.enq_valid = 1'b0;
      #1;
      check("drain_fwd_hit", 32'(sb.ld_hit), 32'd1);
      check("drain_fwd_data", sb.ld_data, 32'hDEADBEEF);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);

      // Backpressure: five stores under stall, the fifth is dropped
      for (int k = 0; k < 5; k++)
         cycle(1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 1'b1);
      check("full_size", 32'(exp_q.size()), 32'd4);

      // Release stall: full with a drain still refuses the enqueue; in-order writes
      cycle(1'b1, 32'h990, 32'hEE, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);

      // Youngest-match forwarding
      cycle(1'b1, 32'h20, 32'h1, 1'b1);
      cycle(1'b1, 32'h20, 32'h2, 1'b1);
      sb.enq_valid = 1'b0;
      sb.ld_addr   = 32'h23;
      #1;
      check("young_hit", 32'(sb.ld_hit), 32'd1);
      check("young_data", sb.ld_data, 32'h2);
      sb.ld_addr = 32'h24;
      #1;
      check("miss_hit", 32'(sb.ld_hit), 32'd0);
      check("miss_data", sb.ld_data, 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);
      sb.ld_addr = 32'h20;
      #1;
      check("second_fwd_data", sb.ld_data, 32'h2);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);

      // Simultaneous enqueue and drain at three entries, pointers wrap past index 3
      cycle(1'b1, 32'h40, 32'hB0, 1'b1);
      cycle(1'b1, 32'h44, 32'hB1, 1'b1);
      cycle(1'b1, 32'h48, 32'hB2, 1'b1);
      cycle(1'b1, 32'h4C, 32'hB3, 1'b0);
      cycle(1'b1, 32'h50, 32'hB4, 1'b0);
      cycle(1'b1, 32'h54, 32'hB5, 1'b0);
      check("steady_size", 32'(exp_q.size()), 32'd3);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0);

      // Mid-operation reset with an enqueue in the same cycle
      cycle(1'b1, 32'h60, 32'hC0, 1'b1);
      cycle(1'b1, 32'h64, 32'hC1, 1'b1);
      cycle(1'b1, 32'h68, 32'hC2, 1'b1);
      reset        = 1'b1;
      sb.enq_valid = 1'b1;
      sb.enq_addr  = 32'h6C;
      sb.enq_data  = 32'hC3;
      @(posedge clk);
      #1;
      reset          = 1'b0;
      sb.enq_valid   = 1'b0;
      sb.drain_stall = 1'b0;
      exp_q.delete();
      #1;
      check("post_rst_empty", 32'(sb.empty), 32'd1);
      check("post_rst_mem_WE", 32'(sb.mem_WE), 32'd0);
      check("post_rst_ready", 32'(sb.enq_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         sb.ld_addr = 32'h60 + 32'(4 * k);
         #1;
         check("post_rst_ld_hit", 32'(sb.ld_hit), 32'd0);
      end
      @(posedge clk);
      #1;
      cycle(1'b0, 32'h0, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of pending-store entries; power of two, 2..16.
REQ-002 SHALL have parameter AW, default 32: address and data width in bits.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enq_valid, input, 1: a retired store is presented this cycle.
REQ-006 SHALL have port enq_addr, input, AW: byte address of the store; bits [1:0] are ignored because stores are word-aligned.
REQ-007 SHALL have port enq_data, input, AW: store data word.
REQ-008 SHALL have port enq_ready, output, 1: the buffer can accept a store this cycle.
REQ-009 SHALL have port drain_stall, input, 1: the data-memory write port is unavailable this cycle.
REQ-010 SHALL have port mem_WE, output, 1: write enable to data memory.
REQ-011 SHALL have port mem_A, output, AW: write address to data memory.
REQ-012 SHALL have port mem_WD, output, AW: write data to data memory.
REQ-013 SHALL have port ld_addr, input, AW: load byte address for the forwarding lookup.
REQ-014 SHALL have port ld_hit, output, 1: a buffered store matches ld_addr.
REQ-015 SHALL have port ld_data, output, AW: forwarded word, valid only when ld_hit is 1.
REQ-016 SHALL have port empty, output, 1: no stores pending (fence/halt indication).

Function
REQ-017 SHALL be a circular FIFO with head pointer, tail pointer and a count of width log2(DEPTH)+1; both pointers wrap modulo DEPTH.
REQ-018 SHALL drive enq_ready = (count != DEPTH); it SHALL NOT depend on a same-cycle drain.
REQ-019 SHALL write an entry at the tail and increment the tail when enq_valid && enq_ready; enq_valid with enq_ready=0 SHALL be ignored with no state change.
REQ-020 SHALL drive mem_WE = !empty && !drain_stall, mem_A = head address, mem_WD = head data, all from registered state with no combinational path from enq_*.
REQ-021 SHALL pop the head (head+1, count-1) on any cycle with mem_WE=1, so there is one store per cycle and strict program order is kept.
REQ-022 SHALL apply enqueue and pop together in one cycle with count unchanged.
REQ-023 SHALL have a minimum latency of 1 cycle from enqueue into an empty buffer to mem_WE=1.
REQ-024 SHALL make the forwarding lookup purely combinational: compare ld_addr[AW-1:2] with every valid entry's addr[AW-1:2].
REQ-025 SHALL return the youngest matching entry (closest to the tail) on multiple matches.
REQ-026 SHALL include the entry being drained this cycle in the lookup, because memory is not yet updated.
REQ-027 SHALL exclude the store being enqueued this cycle from the lookup; no same-cycle bypass.
REQ-028 SHALL drive ld_hit=0 and ld_data=0 when there is no match.
REQ-029 SHALL hold empty = (count == 0).

Reset
REQ-030 SHALL, while reset=1 at a clock edge, set head=0, tail=0 and count=0; entry contents need no reset.
REQ-031 SHALL hold the output values enq_ready=1, mem_WE=0, mem_A=0, mem_WD=0, ld_hit=0, ld_data=0 and empty=1 from reset until the first enqueue.
REQ-032 SHALL discard all pending stores on reset asserted mid-operation, and SHALL ignore an enqueue in the same cycle as reset.

Structure
REQ-033 SHALL take XLEN=32 and SB_DEPTH=4 from the shared package riscv_pkg, which also holds the word-index helper for address[31:2].
REQ-034 SHALL place the youngest-match priority select in one sub-module, sb_fwd_match: inputs are valid mask, age-ordered entries and ld_addr; outputs are hit and data.
REQ-035 SHALL keep the mem_* outputs directly compatible with the existing word-addressed data memory, which writes on the rising edge when WE=1.

Verification
REQ-036 SHALL cover single store: enqueue addr 0x10, data 0xDEADBEEF into an empty buffer -> next cycle mem_WE=1, mem_A=0x10, mem_WD=0xDEADBEEF; the cycle after, empty=1.
REQ-037 SHALL cover full/backpressure: with drain_stall=1, enqueue 5 stores -> enq_ready=0 after the 4th; the 5th is dropped; count=4.
REQ-038 SHALL cover order and stall release: then release drain_stall -> 4 writes on consecutive cycles in enqueue order, then empty=1.
REQ-039 SHALL cover youngest forward: with drain_stall=1, enqueue (0x20, 0x1) then (0x20, 0x2); ld_addr=0x23 -> ld_hit=1, ld_data=0x2. With ld_addr=0x24 -> ld_hit=0.
REQ-040 SHALL cover simultaneous enqueue and drain: at count=4 with a drain, enq_ready=0; at count=3 with both enqueue and drain active, count stays 3 and the pointers wrap correctly past index 3.
REQ-041 SHALL cover mid-operation reset: reset with 3 entries pending -> next cycle empty=1, mem_WE=0, ld_hit=0 for every previously buffered address.
